// File: rtl/jk_cmd_driver.sv
// Queued JK flip-flop command driver: FIFO of 2-bit commands, one-cycle J/K drive, Q feedback check.
// Optional Q compare / sticky error under `JK_CMD_CHECK_EN; without it WAIT is skipped and err is 0.
//
//   state | meaning
//   IDLE  | waiting for a queued command; pops head and latches expected Q
//   DRIVE | j,k carry the popped command for exactly one cycle
//   WAIT  | settle time for the flop, CHECK_WAIT cycles (check build only)
//   CHECK | one cycle: done pulse, count++, Q/QN compared (check build only)
module jk_cmd_driver #(
    parameter int DEPTH      = 4,
    parameter int CHECK_WAIT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    output logic       cmd_ready,
    output logic       j,
    output logic       k,
    input  logic       q,
    input  logic       qn,
    output logic       done,
    output logic       err,
    input  logic       err_clr,
    output logic [7:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, DRIVE, WAIT, CHECK} state_t;

    state_t        state;
    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [1:0]    head;

    always_comb begin
        full      = (occ == OCC_FULL);
        empty     = (occ == '0);
        cmd_ready = !full;
        push      = cmd_valid && !full;
        pop       = (state == IDLE) && !empty;
        head      = mem[rd_ptr];
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

`ifdef JK_CMD_CHECK_EN
    logic       exp_q;
    logic [3:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            j        <= 1'b0;
            k        <= 1'b0;
            done     <= 1'b0;
            count    <= 8'd0;
            exp_q    <= 1'b0;
            wait_cnt <= 4'd0;
            err      <= 1'b0;
        end else begin
            j    <= 1'b0;
            k    <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        j     <= head[1];
                        k     <= head[0];
                        state <= DRIVE;
                        case (head)
                            2'b00:   exp_q <= q;
                            2'b01:   exp_q <= 1'b0;
                            2'b10:   exp_q <= 1'b1;
                            default: exp_q <= ~q;
                        endcase
                    end
                end
                DRIVE: begin
                    wait_cnt <= 4'(CHECK_WAIT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        done  <= 1'b1;
                        state <= CHECK;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: begin
                    count <= count + 8'd1;
                    state <= IDLE;
                end
            endcase
            // A failing compare outranks a clear arriving in the same cycle.
            if (state == CHECK && (q != exp_q || q == qn)) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{err_clr, q, qn, 4'(CHECK_WAIT)};
    assign err        = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            j     <= 1'b0;
            k     <= 1'b0;
            done  <= 1'b0;
            count <= 8'd0;
        end else begin
            j    <= 1'b0;
            k    <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        j     <= head[1];
                        k     <= head[0];
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    done  <= 1'b1;
                    state <= CHECK;
                end
                default: begin
                    count <= count + 8'd1;
                    state <= IDLE;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_jk_cmd_driver.sv
// Directed bench for jk_cmd_driver with a behavioural JK flop closing the Q/QN loop.
module tb_jk_cmd_driver;

`ifdef JK_CMD_CHECK_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       err_clr = 1'b0;
    logic       stuck_en = 1'b0;
    logic       stuck_val = 1'b0;
    logic       q_m;
    logic       q;
    logic       qn;
    logic       cmd_ready;
    logic       j;
    logic       k;
    logic       done;
    logic       err;
    logic [7:0] count;

    int vectors = 0;
    int miscompares = 0;
    int done_total = 0;

    jk_cmd_driver #(.DEPTH(4), .CHECK_WAIT(2)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ready(cmd_ready), .j(j), .k(k), .q(q), .qn(qn),
        .done(done), .err(err), .err_clr(err_clr), .count(count)
    );

    always #5 clk = ~clk;

    // Downstream JK flip-flop model; can be overridden with a stuck value.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_m <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   q_m <= 1'b0;
                2'b10:   q_m <= 1'b1;
                2'b11:   q_m <= ~q_m;
                default: q_m <= q_m;
            endcase
        end
    end
    assign q  = stuck_en ? stuck_val : q_m;
    assign qn = ~q;

    always @(posedge clk) if (done === 1'b1) done_total <= done_total + 1;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; err_clr = 1'b0; stuck_en = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    // Push one command into an idle, empty driver; returns at the negedge where done is seen.
    task automatic run_one(input logic [1:0] c, output int lat, output logic [1:0] jk1, output logic [1:0] jk2);
        lat = 99; jk1 = 2'bxx; jk2 = 2'bxx;
        cmd_valid = 1'b1; cmd = c;
        step();
        cmd_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 1) jk1 = {j, k};
            if (i == 2) jk2 = {j, k};
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int lat, base, ndone, pulses, acc_exp, pushed;
        logic [1:0] jk1, jk2;
        logic [4:0] rdy, rdy_exp;
        logic qexp, rdy7_exp, seen255, fin;

        // Reset state
        step(); step();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_jk", {j, k}, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_count", count, 0);
        rst_n = 1'b1;

        // Single set command, pushed on the first edge after reset release
        run_one(2'b10, lat, jk1, jk2);
        chk("set_jk_drive", jk1, 2'b10);
        chk("set_jk_after", jk2, 2'b00);
        chk("set_latency", lat, LAT);
        step();
        chk("set_count", count, 1);
        chk("set_err", err, 0);
        chk("set_q", q, 1);

        // Four back-to-back toggles from q=0
        do_reset();
        base = done_total; ndone = 0; pulses = 0; qexp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cmd_valid = (i < 4); cmd = 2'b11;
            if (done === 1'b1) begin
                chk("tog_q_at_done", q, qexp);
                qexp = ~qexp;
                ndone++;
            end
            if ({j, k} === 2'b11) pulses++;
            step();
        end
        cmd_valid = 1'b0;
        chk("tog_jk_pulses", pulses, 4);
        chk("tog_dones", ndone, 4);
        chk("tog_count", count, 4);
        chk("tog_err", err, 0);

        // FIFO fill while the FSM is busy with a first command
`ifdef JK_CMD_CHECK_EN
        rdy_exp = 5'b11110; rdy7_exp = 1'b1; acc_exp = 4;
`else
        rdy_exp = 5'b11111; rdy7_exp = 1'b0; acc_exp = 5;
`endif
        do_reset();
        base = done_total;
        cmd_valid = 1'b1; cmd = 2'b00;
        step();
        cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1; cmd = 2'b00;
            rdy[4-i] = cmd_ready;
            step();
        end
        cmd_valid = 1'b0;
        chk("fill_ready_seq", rdy, rdy_exp);
        chk("fill_ready_next", cmd_ready, rdy7_exp);
        repeat (40) step();
        chk("fill_dones", done_total - base, 1 + acc_exp);
        chk("fill_count", count, 1 + acc_exp);

        // Q stuck at 0 with a set command
        do_reset();
        stuck_en = 1'b1; stuck_val = 1'b0;
        run_one(2'b10, lat, jk1, jk2);
        chk("stuck_latency", lat, LAT);
        chk("stuck_err_in_check", err, 0);
        step();
`ifdef JK_CMD_CHECK_EN
        chk("stuck_err_set", err, 1);
        repeat (3) step();
        chk("stuck_err_sticky", err, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("stuck_err_clr", err, 0);
        run_one(2'b10, lat, jk1, jk2);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("stuck_set_wins", err, 1);
`else
        chk("nochk_err_tied", err, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("nochk_err_clr", err, 0);
`endif
        stuck_en = 1'b0;

        // Reset mid-command with commands queued
        do_reset();
        base = done_total;
        cmd = 2'b10; cmd_valid = 1'b1;
        step(); step();
`ifdef JK_CMD_CHECK_EN
        step();
`endif
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_jk", {j, k}, 0);
        chk("abort_done", done, 0);
        chk("abort_count", count, 0);
        chk("abort_ready", cmd_ready, 1);
        step(); step();
        rst_n = 1'b1;
        repeat (12) step();
        chk("abort_no_done", done_total - base, 0);
        chk("abort_count_after", count, 0);
        chk("abort_fifo_empty", cmd_ready, 1);

        // 256 commands: count wraps to zero
        do_reset();
        base = done_total; pushed = 0; seen255 = 1'b0; fin = 1'b0;
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            if (pushed < 256) begin
                cmd_valid = 1'b1; cmd = 2'b00;
                if (cmd_ready) pushed++;
            end else begin
                cmd_valid = 1'b0;
            end
            step();
            if (done_total - base == 255 && !seen255) begin
                seen255 = 1'b1;
                chk("wrap_count_255", count, 255);
            end
            if (done_total - base == 256) fin = 1'b1;
        end
        cmd_valid = 1'b0;
        chk("wrap_seen_255", seen255, 1);
        chk("wrap_dones", done_total - base, 256);
        chk("wrap_count_0", count, 0);
        chk("wrap_err", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
